// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB3 completer backed by a word-addressed memory with WAIT_STATES wait cycles.
// Defining APB_SLV_PSLVERR_EN adds a PSLVERR output flagging out-of-range accesses.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY
`ifdef APB_SLV_PSLVERR_EN
  ,
  output logic                  PSLVERR
`endif
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]       WS        = 4'(WAIT_STATES);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  err_q, err_d;
  logic                  mem_we_s;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic [IDX_W-1:0]      idx_in_s;
  logic                  in_range_in_s;
  logic                  in_range_q_s;
  logic [DATA_WIDTH-1:0] rd_in_s;
  logic [DATA_WIDTH-1:0] rd_q_s;
  logic                  unused_addr_s;

  assign idx_in_s      = PADDR[ADDR_WIDTH-1:2];
  assign in_range_in_s = (idx_in_s < DEPTH_IDX);
  assign in_range_q_s  = (idx_q < DEPTH_IDX);
  assign rd_in_s       = in_range_in_s ? mem_q[idx_in_s[MEM_AW-1:0]] : ZERO;
  assign rd_q_s        = in_range_q_s ? mem_q[idx_q[MEM_AW-1:0]] : ZERO;
  assign unused_addr_s = ^PADDR[1:0];

  // Next-state, wait counter, response and write-enable logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    pready_d = pready_q;
    prdata_d = prdata_q;
    err_d    = err_q;
    mem_we_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          idx_d    = idx_in_s;
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          cnt_d    = WS;
          pready_d = (WS == 4'd0);
          err_d    = (WS == 4'd0) && !in_range_in_s;
          if ((WS == 4'd0) && !PWRITE) begin
            prdata_d = rd_in_s;
          end else begin
            prdata_d = ZERO;
          end
          state_d  = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      // With zero wait states the first access cycle is spent in SETUP, so both states share this path.
      SETUP, ACCESS: begin
        if (!PSEL) begin
          state_d  = IDLE;
          cnt_d    = 4'd0;
          pready_d = 1'b0;
          prdata_d = ZERO;
          err_d    = 1'b0;
        end else if (PENABLE && pready_q) begin
          mem_we_s = write_q && in_range_q_s;
          state_d  = IDLE;
          cnt_d    = 4'd0;
          pready_d = 1'b0;
          prdata_d = ZERO;
          err_d    = 1'b0;
        end else begin
          state_d = ACCESS;
          if (!pready_q && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              pready_d = 1'b1;
              err_d    = !in_range_q_s;
              prdata_d = write_q ? ZERO : rd_q_s;
            end else begin
              pready_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = 4'd0;
        pready_d = 1'b0;
        prdata_d = ZERO;
        err_d    = 1'b0;
      end
    endcase
  end

  // State, response and memory registers; reset clears the whole memory.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      idx_q    <= {IDX_W{1'b0}};
      write_q  <= 1'b0;
      wdata_q  <= ZERO;
      cnt_q    <= 4'd0;
      pready_q <= 1'b0;
      prdata_q <= ZERO;
      err_q    <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= ZERO;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
      err_q    <= err_d;
      if (mem_we_s) begin
        mem_q[idx_q[MEM_AW-1:0]] <= wdata_q;
      end
    end
  end

  assign PRDATA = prdata_q;
  assign PREADY = pready_q;

`ifdef APB_SLV_PSLVERR_EN
  assign PSLVERR = err_q;
`else
  logic unused_err_s;
  assign unused_err_s = err_q;
`endif

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed self-checking bench for apb_slave_mem: one instance with 2 wait states, one with none.
module tb_apb_slave_mem;

  logic        pclk;
  logic        presetn;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        penable;
  logic        psel_a;
  logic        psel_b;
  logic [31:0] prdata_a;
  logic [31:0] prdata_b;
  logic        pready_a;
  logic        pready_b;
`ifdef APB_SLV_PSLVERR_EN
  logic        pslverr_a;
  logic        pslverr_b;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut_a (
    .PCLK(pclk), .PRESETn(presetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel_a), .PENABLE(penable), .PRDATA(prdata_a), .PREADY(pready_a)
`ifdef APB_SLV_PSLVERR_EN
    , .PSLVERR(pslverr_a)
`endif
  );

  apb_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut_b (
    .PCLK(pclk), .PRESETn(presetn), .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite),
    .PSEL(psel_b), .PENABLE(penable), .PRDATA(prdata_b), .PREADY(pready_b)
`ifdef APB_SLV_PSLVERR_EN
    , .PSLVERR(pslverr_b)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Full APB transfer starting just after an edge; ACCESS-phase bus values are scrambled on purpose.
  task automatic apb_xfer(input bit use_b, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output int acc_cycles, output int low_cycles, output logic err);
    logic rdy;
    psel_a  = !use_b;
    psel_b  = use_b;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge pclk); #1;
    penable    = 1'b1;
    paddr      = ~addr;
    pwdata     = ~wdata;
    pwrite     = ~wr;
    acc_cycles = 0;
    low_cycles = 0;
    rdata      = 32'h0;
    err        = 1'b0;
    rdy        = 1'b0;
    while (!rdy && acc_cycles < 20) begin
      rdy = use_b ? pready_b : pready_a;
      acc_cycles++;
      if (rdy) begin
        rdata = use_b ? prdata_b : prdata_a;
`ifdef APB_SLV_PSLVERR_EN
        err = use_b ? pslverr_b : pslverr_a;
`endif
      end else begin
        low_cycles++;
      end
      @(posedge pclk); #1;
    end
    if (!rdy) begin
      total_cnt++;
      $display("FAIL xfer_timeout addr=%h: PREADY never seen, required within 20 cycles", addr);
    end
    total_cnt++;
    if ((use_b ? pready_b : pready_a) !== 1'b0) begin
      $display("FAIL pready_pulse addr=%h: PREADY=%b after completion, required 0", addr,
               (use_b ? pready_b : pready_a));
    end else begin
      pass_cnt++;
    end
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    repeat (3) @(posedge pclk);
    #1;
    total_cnt++;
    if (pready_a !== 1'b0) $display("FAIL reset_pready_a: got %b, required 0", pready_a);
    else pass_cnt++;
    total_cnt++;
    if (prdata_a !== 32'h0) $display("FAIL reset_prdata_a: got %h, required 00000000", prdata_a);
    else pass_cnt++;
    total_cnt++;
    if (pready_b !== 1'b0) $display("FAIL reset_pready_b: got %b, required 0", pready_b);
    else pass_cnt++;
    total_cnt++;
    if (prdata_b !== 32'h0) $display("FAIL reset_prdata_b: got %h, required 00000000", prdata_b);
    else pass_cnt++;
    presetn = 1'b1;
  endtask

  task automatic test_read_wait();
    logic [31:0] rd; int acc; int low; logic err;
    apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (low !== 2) $display("FAIL read_wait_low: got %0d low cycles, required 2", low);
    else pass_cnt++;
    total_cnt++;
    if (acc !== 3) $display("FAIL read_wait_latency: got %0d cycles, required 3", acc);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL read_wait_data: got %h, required 00000000", rd);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int acc; int low; logic err;
    apb_xfer(1'b0, 1'b1, 32'h04, 32'hDEAD_BEEF, rd, acc, low, err);
    total_cnt++;
    if (acc !== 3) $display("FAIL b2b_write_latency: got %0d cycles, required 3", acc);
    else pass_cnt++;
    apb_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (acc !== 3) $display("FAIL b2b_read_latency: got %0d cycles, required 3", acc);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hDEAD_BEEF) $display("FAIL b2b_read_data: got %h, required deadbeef", rd);
    else pass_cnt++;
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd; int acc; int low; logic err;
    apb_xfer(1'b1, 1'b1, 32'h3FC, 32'h1234_5678, rd, acc, low, err);
    total_cnt++;
    if (acc !== 1) $display("FAIL zw_write_latency: got %0d cycles, required 1", acc);
    else pass_cnt++;
    apb_xfer(1'b1, 1'b0, 32'h3FC, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (low !== 0) $display("FAIL zw_read_low: got %0d low cycles, required 0", low);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'h1234_5678) $display("FAIL zw_read_data: got %h, required 12345678", rd);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int acc; int low; logic err;
    apb_xfer(1'b0, 1'b1, 32'h400, 32'hAAAA_5555, rd, acc, low, err);
    total_cnt++;
    if (acc !== 3) $display("FAIL oor_write_latency: got %0d cycles, required 3", acc);
    else pass_cnt++;
`ifdef APB_SLV_PSLVERR_EN
    total_cnt++;
    if (err !== 1'b1) $display("FAIL oor_pslverr: got %b with PREADY, required 1", err);
    else pass_cnt++;
`endif
    apb_xfer(1'b0, 1'b0, 32'h000, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL oor_alias_read: got %h, required 00000000", rd);
    else pass_cnt++;
`ifdef APB_SLV_PSLVERR_EN
    total_cnt++;
    if (err !== 1'b0) $display("FAIL inrange_pslverr: got %b, required 0", err);
    else pass_cnt++;
`endif
    apb_xfer(1'b0, 1'b0, 32'h400, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL oor_read_data: got %h, required 00000000", rd);
    else pass_cnt++;
    total_cnt++;
    if (acc !== 3) $display("FAIL oor_read_latency: got %0d cycles, required 3", acc);
    else pass_cnt++;
    apb_xfer(1'b1, 1'b0, 32'h7FC, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL oor_read_zw: got %h, required 00000000", rd);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    logic [31:0] rd; int acc; int low; logic err; logic seen;
    apb_xfer(1'b0, 1'b1, 32'h0C, 32'h1111_2222, rd, acc, low, err);
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h3333_4444;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel_a = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      seen = seen | pready_a;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_no_pready: got PREADY pulse %b, required 0", seen);
    else pass_cnt++;
    apb_xfer(1'b0, 1'b0, 32'h0C, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (rd !== 32'h1111_2222) $display("FAIL abort_read_data: got %h, required 11112222", rd);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int acc; int low; logic err;
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hFFFF_FFFF;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    total_cnt++;
    if (pready_a !== 1'b0) $display("FAIL rst_mid_pready: got %b, required 0", pready_a);
    else pass_cnt++;
    psel_a = 1'b0; penable = 1'b0; presetn = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(1'b0, 1'b0, 32'h08, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL rst_mid_read: got %h, required 00000000", rd);
    else pass_cnt++;
    apb_xfer(1'b0, 1'b0, 32'h04, 32'h0, rd, acc, low, err);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL rst_mem_clear: got %h, required 00000000", rd);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_wait();
    test_back_to_back();
    test_zero_wait();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
